// File: rtl/vend_ctrl_scan_if.sv
// Board-side bundle of the vending controller: UART byte strobe and dispenser handshake in; change, credit and display out.
// master = UART/dispenser side driving the controller, slave = the controller itself.
interface vend_ctrl_scan_if #(
    parameter int unsigned DIGITS = 2
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              dispense_ack;
    logic              dispense_req;
    logic              change_valid;
    logic [7:0]        change;
    logic              coin_reject;
    logic [7:0]        credit;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    modport master (
        output rx_data, rx_valid, dispense_ack,
        input  dispense_req, change_valid, change, coin_reject, credit, seg, an
    );

    modport slave (
        input  rx_data, rx_valid, dispense_ack,
        output dispense_req, change_valid, change, coin_reject, credit, seg, an
    );
endinterface

// File: rtl/vend_ctrl_scan.sv
// Vending controller: command bytes -> credit, dispense handshake, change/refund, multiplexed 7-seg credit display.
// All outputs registered (one-cycle latency); rx is never stalled, dispense_req is held until dispense_ack.
module vend_ctrl_scan #(
    parameter int unsigned PRICE      = 15,
    parameter int unsigned MAX_CREDIT = 99,
    parameter int unsigned DIGITS     = 2,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned TIMEOUT    = 500000000,
    parameter logic [7:0]  CH_ONE     = 8'd97,
    parameter logic [7:0]  CH_FIVE    = 8'd98,
    parameter logic [7:0]  CH_TEN     = 8'd99,
    parameter logic [7:0]  CH_CANCEL  = 8'd115,
    parameter logic [7:0]  CH_CLEAR   = 8'd114
) (
    input  logic             clk,
    input  logic             reset,
    vend_ctrl_scan_if.slave  bus
);

    localparam int unsigned TW = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

    localparam logic [8:0]    PRICE_W  = 9'(PRICE);
    localparam logic [7:0]    PRICE_B  = 8'(PRICE);
    localparam logic [8:0]    MAX_W    = 9'(MAX_CREDIT);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] DIV_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [6:0]    SEG_ZERO = 7'b1000000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_PAY     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      credit_q, credit_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            dispense_req_q, dispense_req_d;
    logic            change_valid_q, change_valid_d;
    logic [7:0]      change_q, change_d;
    logic            coin_reject_q, coin_reject_d;
    logic [SW-1:0]   div_q, div_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]      seg_q, seg_d;

    logic            coin_hit;
    logic [7:0]      coin_val;
    logic            is_cancel;
    logic            is_clear;
    logic [8:0]      sum;
    logic            coin_ok;
    logic            timed_out;
    logic [7:0]      pay_amt;

    // Byte decode; a coin that does not fit or arrives outside IDLE/COLLECT is rejected
    always_comb begin
        coin_hit = 1'b0;
        coin_val = 8'd0;
        if (bus.rx_valid) begin
            if (bus.rx_data == CH_ONE) begin
                coin_hit = 1'b1;
                coin_val = 8'd1;
            end else if (bus.rx_data == CH_FIVE) begin
                coin_hit = 1'b1;
                coin_val = 8'd5;
            end else if (bus.rx_data == CH_TEN) begin
                coin_hit = 1'b1;
                coin_val = 8'd10;
            end
        end
        is_cancel = bus.rx_valid && (bus.rx_data == CH_CANCEL);
        is_clear  = bus.rx_valid && (bus.rx_data == CH_CLEAR);
        sum       = {1'b0, credit_q} + {1'b0, coin_val};
        coin_ok   = coin_hit && (sum <= MAX_W) &&
                    ((state_q == S_IDLE) || (state_q == S_COLLECT));
        timed_out = (state_q == S_COLLECT) && (timer_q == TO_LAST);
    end

    // Next-state process; an accepted coin outranks cancel and timeout
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        timer_d  = '0;
        pay_amt  = 8'd0;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (coin_ok) begin
                    credit_d = sum[7:0];
                    state_d  = (sum >= PRICE_W) ? S_VEND : S_COLLECT;
                end else if ((state_q == S_COLLECT) && (is_cancel || timed_out)) begin
                    state_d = S_PAY;
                    pay_amt = credit_q;
                end else if (state_q == S_COLLECT) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_VEND: begin
                if (bus.dispense_ack) begin
                    state_d = S_PAY;
                    pay_amt = credit_q - PRICE_B;
                end
            end
            S_PAY: begin
                state_d  = S_IDLE;
                credit_d = 8'd0;
            end
            default: state_d = S_IDLE;
        endcase
        if (is_clear) begin
            state_d  = S_IDLE;
            credit_d = 8'd0;
            timer_d  = '0;
            pay_amt  = 8'd0;
        end
    end

    // Output process: registered outputs follow the state being entered
    always_comb begin
        dispense_req_d = (state_d == S_VEND);
        change_valid_d = (state_d == S_PAY);
        change_d       = pay_amt;
        coin_reject_d  = coin_hit && !coin_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            credit_q       <= 8'd0;
            timer_q        <= '0;
            dispense_req_q <= 1'b0;
            change_valid_q <= 1'b0;
            change_q       <= 8'd0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            timer_q        <= timer_d;
            dispense_req_q <= dispense_req_d;
            change_valid_q <= change_valid_d;
            change_q       <= change_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

    logic [11:0] bcd;
    logic [19:0] dd;
    logic [3:0]  digit_a [4];
    logic [1:0]  sel;
    logic [3:0]  digit;

    // Double-dabble: 8-bit credit into three BCD digits
    always_comb begin
        dd = {12'd0, credit_q};
        for (int i = 0; i < 8; i++) begin
            for (int d = 0; d < 3; d++) begin
                if (dd[8 + 4*d +: 4] >= 4'd5) begin
                    dd[8 + 4*d +: 4] = dd[8 + 4*d +: 4] + 4'd3;
                end
            end
            dd = dd << 1;
        end
        bcd = dd[19:8];
    end

    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        digit_a[0] = bcd[3:0];
        digit_a[1] = bcd[7:4];
        digit_a[2] = bcd[11:8];
        digit_a[3] = 4'd0;
        sel   = 2'(idx_d);
        digit = digit_a[sel];
        an_d  = ~(DIGITS'(1) << idx_d);
        case (digit)
            4'd0:    seg_d = 7'b1000000;
            4'd1:    seg_d = 7'b1111001;
            4'd2:    seg_d = 7'b0100100;
            4'd3:    seg_d = 7'b0110000;
            4'd4:    seg_d = 7'b0011001;
            4'd5:    seg_d = 7'b0010010;
            4'd6:    seg_d = 7'b0000010;
            4'd7:    seg_d = 7'b1111000;
            4'd8:    seg_d = 7'b0000000;
            4'd9:    seg_d = 7'b0010000;
            default: seg_d = 7'b1111111;
        endcase
    end

    // Soft clear leaves the scan position alone; only hard reset rewinds it
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
            an_q  <= ~DIGITS'(1);
            seg_q <= SEG_ZERO;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bus.dispense_req = dispense_req_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change       = change_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.credit       = credit_q;
    assign bus.seg          = seg_q;
    assign bus.an           = an_q;

endmodule

// File: tb/tb_vend_ctrl_scan.sv
// Directed bench: three controller instances (default price, PRICE=95 with fast scan, PRICE=5) on a shared clock and reset.
module tb_vend_ctrl_scan;

    logic       clk;
    logic       reset;
    logic [7:0] rx_byte;
    logic [2:0] rx_vld;
    logic [2:0] ack;

    int n_checks = 0;
    int n_errors = 0;

    vend_ctrl_scan_if #(.DIGITS(2)) if_a ();
    vend_ctrl_scan_if #(.DIGITS(2)) if_b ();
    vend_ctrl_scan_if #(.DIGITS(2)) if_c ();

    assign if_a.rx_data = rx_byte;
    assign if_b.rx_data = rx_byte;
    assign if_c.rx_data = rx_byte;
    assign if_a.rx_valid = rx_vld[0];
    assign if_b.rx_valid = rx_vld[1];
    assign if_c.rx_valid = rx_vld[2];
    assign if_a.dispense_ack = ack[0];
    assign if_b.dispense_ack = ack[1];
    assign if_c.dispense_ack = ack[2];

    vend_ctrl_scan #(.TIMEOUT(100)) u_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    vend_ctrl_scan #(.PRICE(95), .SCAN_DIV(4)) u_b (.clk(clk), .reset(reset), .bus(if_b.slave));
    vend_ctrl_scan #(.PRICE(5)) u_c (.clk(clk), .reset(reset), .bus(if_c.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int which, input logic [7:0] b);
        rx_byte = b;
        rx_vld[which] = 1'b1;
        tick();
        rx_vld = 3'b000;
    endtask

    task automatic pulse_ack(input int which);
        ack[which] = 1'b1;
        tick();
        ack = 3'b000;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt;
        int held;
        logic [1:0] prev;
        logic [1:0] exp_an;
        logic [6:0] exp_seg;

        clk = 1'b0;
        reset = 1'b1;
        rx_byte = 8'd0;
        rx_vld = 3'b000;
        ack = 3'b000;
        repeat (2) tick();
        chk("rst_credit", if_a.credit, 0);
        chk("rst_req", if_a.dispense_req, 0);
        chk("rst_cvld", if_a.change_valid, 0);
        chk("rst_change", if_a.change, 0);
        chk("rst_reject", if_a.coin_reject, 0);
        chk("rst_an", if_a.an, 2'b10);
        chk("rst_seg", if_a.seg, 7'b1000000);
        reset = 1'b0;
        tick();

        // Exact price: 'c','b' -> 10, 15, VEND, change 0
        send(0, "c");
        chk("c_credit10", if_a.credit, 10);
        chk("c_noreq", if_a.dispense_req, 0);
        send(0, "b");
        chk("b_credit15", if_a.credit, 15);
        chk("b_req", if_a.dispense_req, 1);
        pulse_ack(0);
        chk("ack_req_low", if_a.dispense_req, 0);
        chk("ack_cvld", if_a.change_valid, 1);
        chk("ack_change0", if_a.change, 0);
        chk("ack_credit_hold", if_a.credit, 15);
        tick();
        chk("pay_cvld_drop", if_a.change_valid, 0);
        chk("pay_credit0", if_a.credit, 0);

        // Overpay 20, ack after 7 cycles -> change 5
        send(0, "c");
        send(0, "c");
        chk("cc_credit20", if_a.credit, 20);
        cnt = 0;
        repeat (7) begin
            if (if_a.dispense_req === 1'b1) cnt++;
            tick();
        end
        chk("req_held7", cnt, 7);
        chk("req_still", if_a.dispense_req, 1);
        pulse_ack(0);
        chk("cc_cvld", if_a.change_valid, 1);
        chk("cc_change5", if_a.change, 5);
        tick();

        // Inactivity refund after exactly TIMEOUT cycles in COLLECT
        send(0, "b");
        send(0, "a");
        chk("to_credit6", if_a.credit, 6);
        repeat (99) tick();
        chk("to_not_yet", if_a.change_valid, 0);
        tick();
        chk("to_cvld", if_a.change_valid, 1);
        chk("to_change6", if_a.change, 6);
        tick();
        chk("to_idle_credit", if_a.credit, 0);

        // Cancel refund, then soft clear with credit 3
        send(0, "a"); send(0, "a"); send(0, "a");
        send(0, "s");
        chk("cancel_cvld", if_a.change_valid, 1);
        chk("cancel_change3", if_a.change, 3);
        tick();
        send(0, "a"); send(0, "a"); send(0, "a");
        chk("pre_clear3", if_a.credit, 3);
        send(0, "r");
        chk("clear_credit0", if_a.credit, 0);
        chk("clear_nocvld", if_a.change_valid, 0);
        tick();
        chk("clear_nocvld2", if_a.change_valid, 0);

        // Cancel and ack in IDLE are ignored
        send(0, "s");
        chk("idle_cancel", if_a.change_valid, 0);
        pulse_ack(0);
        chk("idle_ack", if_a.change_valid, 0);
        chk("idle_ack_req", if_a.dispense_req, 0);

        // Instance B: credit 37 scanned as "7" on an=10, "3" on an=01, 4 cycles each
        send(1, "c"); send(1, "c"); send(1, "c");
        send(1, "b"); send(1, "a"); send(1, "a");
        chk("b_credit37", if_b.credit, 37);
        cnt = 0;
        prev = if_b.an;
        tick();
        while (!(prev == 2'b01 && if_b.an == 2'b10) && cnt < 20) begin
            prev = if_b.an;
            tick();
            cnt++;
        end
        chk("scan_align", (cnt < 20), 1);
        exp_an = 2'b10;
        for (int s = 0; s < 4; s++) begin
            exp_seg = (exp_an == 2'b10) ? 7'b1111000 : 7'b0110000;
            chk("scan_an", if_b.an, exp_an);
            chk("scan_seg", if_b.seg, exp_seg);
            held = 0;
            do begin
                tick();
                held++;
            end while (if_b.an === exp_an && held < 10);
            chk("scan_hold4", held, 4);
            exp_an = ~exp_an;
        end

        // Instance B: overflow reject at 90, then 95 reaches price
        send(1, "r");
        chk("b_clear", if_b.credit, 0);
        repeat (9) send(1, "c");
        chk("b_credit90", if_b.credit, 90);
        send(1, "c");
        chk("b_ovf_reject", if_b.coin_reject, 1);
        chk("b_ovf_credit", if_b.credit, 90);
        tick();
        chk("b_reject_pulse", if_b.coin_reject, 0);
        send(1, "b");
        chk("b_credit95", if_b.credit, 95);
        chk("b_req95", if_b.dispense_req, 1);
        pulse_ack(1);
        chk("b_change0", if_b.change, 0);
        chk("b_cvld", if_b.change_valid, 1);
        tick();

        // Instance C (PRICE=5): coin in VEND rejected, coin+ack same cycle
        send(2, "b");
        chk("c5_req", if_c.dispense_req, 1);
        send(2, "c");
        chk("c5_vend_reject", if_c.coin_reject, 1);
        chk("c5_vend_credit", if_c.credit, 5);
        chk("c5_req_hold", if_c.dispense_req, 1);
        pulse_ack(2);
        chk("c5_change0", if_c.change, 0);
        chk("c5_cvld", if_c.change_valid, 1);
        tick();
        send(2, "b");
        rx_byte = "c";
        rx_vld[2] = 1'b1;
        ack[2] = 1'b1;
        tick();
        rx_vld = 3'b000;
        ack = 3'b000;
        chk("both_reject", if_c.coin_reject, 1);
        chk("both_cvld", if_c.change_valid, 1);
        chk("both_req_low", if_c.dispense_req, 0);
        tick();

        // Hard reset while vending: request drops, no change issued
        send(0, "c");
        send(0, "b");
        chk("rv_req", if_a.dispense_req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rv_req_low", if_a.dispense_req, 0);
        chk("rv_nocvld", if_a.change_valid, 0);
        chk("rv_credit0", if_a.credit, 0);
        tick();
        chk("rv_nocvld2", if_a.change_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
